// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle right shifter for SRL/SRA/SRLI/SRAI.
// It uses a start/busy/done handshake and shifts one bit per cycle.
// When the macro SHIFT_RIGHT_NIBBLE_EN is defined, it shifts 4 bits per cycle
// while at least 4 bits of shift remain.
//
// Parameters
//   n      operand / result width (n >= 2; n >= 4 when SHIFT_RIGHT_NIBBLE_EN)
//   sw     shift-amount width, clog2(n)
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, accepted in IDLE or in the DONE cycle
//   a      operand, captured on accept
//   shamt  shift amount, captured on accept
//   arith  1 = sign fill, 0 = zero fill
//   busy   high from the accept edge until done rises
//   done   one-cycle result-valid pulse
//   y      result register; partial values are visible while busy
module shift_right_seq #(
    parameter int unsigned n  = 32,
    parameter int unsigned sw = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [n-1:0]  a,
    input  logic [sw-1:0] shamt,
    input  logic          arith,
    output logic          busy,
    output logic          done,
    output logic [n-1:0]  y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [sw-1:0] cnt;
    logic          fill;

    logic          accept;
    logic          shift_en;
    logic          nib;
    logic [sw-1:0] step;
    logic          last_step;
    logic [n-1:0]  y_shifted;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    state_nxt = accept ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control decode: accept, step size, and whether this is the final step
    always_comb begin
        accept    = 1'b0;
        shift_en  = 1'b0;
        nib       = 1'b0;
        step      = sw'(1);
        last_step = 1'b0;
        if (state == IDLE || state == DONE) begin
            accept = start;
        end
        if (state == SHIFT) begin
            shift_en = (cnt != '0);
`ifdef SHIFT_RIGHT_NIBBLE_EN
            if (cnt >= sw'(4)) begin
                nib  = 1'b1;
                step = sw'(4);
            end
`endif
            // Zero remaining shift also finishes here, leaving y untouched
            last_step = (cnt <= step);
        end
    end

    // Single-step or nibble-step shift, with the frozen fill bit
    always_comb begin
        y_shifted = {fill, y[n-1:1]};
`ifdef SHIFT_RIGHT_NIBBLE_EN
        if (nib) begin
            y_shifted = {{4{fill}}, y[n-1:4]};
        end
`else
        if (nib) begin
            y_shifted = y;
        end
`endif
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            y    <= '0;
            cnt  <= '0;
            fill <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == SHIFT);
            done <= (state_nxt == DONE);
            if (accept) begin
                y    <= a;
                cnt  <= shamt;
                fill <= arith & a[n-1];
            end else if (shift_en) begin
                y   <= y_shifted;
                cnt <= cnt - step;
            end
        end
    end

endmodule

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;

    localparam int unsigned N  = 32;
    localparam int unsigned SW = 5;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  a;
    logic [SW-1:0] shamt;
    logic          arith;
    logic          busy;
    logic          done;
    logic [N-1:0]  y;

    shift_right_seq #(.n(N), .sw(SW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .shamt (shamt),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] exp_y;
        int           t0;
        int           lat;
    } item_t;

    item_t sb[$];
    int    cyc    = 0;
    int    tests  = 0;
    int    fails  = 0;
    bit    mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int s);
        int l;
`ifdef SHIFT_RIGHT_NIBBLE_EN
        l = s / 4 + s % 4;
`else
        l = s;
`endif
        return (l < 1) ? 1 : l;
    endfunction

    // Reference result: plain logical / arithmetic shift of the operand
    function automatic logic [N-1:0] ref_y(input logic [N-1:0] v, input int s, input logic ar);
        logic [N-1:0] r;
        if (ar) r = $signed(v) >>> s;
        else    r = v >> s;
        return r;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse, checks busy in between
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'(0));
                end else begin
                    item_t it;
                    it = sb.pop_front();
                    chk("result_y", y, it.exp_y);
                    chk("latency", 32'(cyc - it.t0), 32'(it.lat));
                    chk("busy_in_done", 32'(busy), 32'(0));
                end
            end else if (sb.size() > 0 && cyc >= sb[0].t0) begin
                if (cyc >= sb[0].t0 + sb[0].lat) begin
                    chk("done_timeout", 32'(done), 32'(1));
                    void'(sb.pop_front());
                end else begin
                    chk("busy_during_shift", 32'(busy), 32'(1));
                end
            end
        end
    end

    // Issue one operation as soon as the block is idle; pulses ignored starts while busy
    task automatic issue(input logic [N-1:0] va, input int s, input logic ar, input logic [N-1:0] ey);
        int g;
        item_t it;
        g = 0;
        while (busy === 1'b1 && g < 200) begin
            start = ($urandom_range(0, 3) == 0);
            a     = $urandom;
            shamt = SW'($urandom);
            arith = 1'($urandom);
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("idle_wait_timeout", 32'(busy), 32'(0));
        start = 1'b1;
        a     = va;
        shamt = SW'(s);
        arith = ar;
        it.exp_y = ey;
        it.t0    = cyc + 1;
        it.lat   = lat_of(s);
        sb.push_back(it);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        shamt = SW'($urandom);
        arith = 1'($urandom);
    endtask

    logic [N-1:0] d_a   [7] = '{32'h8000_00F0, 32'h8000_00F0, 32'hDEAD_BEEF,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0010};
    int           d_s   [7] = '{4, 4, 0, 31, 31, 8, 1};
    logic         d_ar  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [N-1:0] d_exp [7] = '{32'h0800_000F, 32'hF800_000F, 32'hDEAD_BEEF,
                                32'h0000_0001, 32'hFFFF_FFFF, 32'h0012_3456, 32'h0000_0008};

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        shamt = '0;
        arith = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_y", y, 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed cases, back-to-back through the DONE cycle
        for (int i = 0; i < 7; i++) begin
            issue(d_a[i], d_s[i], d_ar[i], d_exp[i]);
        end

        // Randomized operations with random idle gaps
        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] ra;
            int           rs;
            logic         rar;
            ra  = $urandom;
            rs  = $urandom_range(0, N - 1);
            rar = 1'($urandom);
            issue(ra, rs, rar, ref_y(ra, rs, rar));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        begin
            int g;
            g = 0;
            while (sb.size() > 0 && g < 100) begin
                @(negedge clk);
                g++;
            end
            chk("drain", 32'(sb.size()), 32'(0));
        end

        // Reset during an in-flight shamt=20 operation abandons it
        begin
            int g;
            g = 0;
            start = 1'b0;
            while (busy === 1'b1 && g < 100) begin
                @(negedge clk);
                g++;
            end
        end
        start = 1'b1;
        a     = 32'hA5A5_1234;
        shamt = SW'(20);
        arith = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_y", y, 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", 32'(done), 32'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
